// File: rtl/ripple_circuit_adder.sv
// Registered WIDTH-bit ripple-carry adder: {cout, sum} = a + b + cin, one cycle latency.
// overflow flags two's-complement overflow (carry into MSB xor carry out of MSB).
module ripple_circuit_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] stage_sum;

    logic [WIDTH-1:0] sum_d,  sum_q;
    logic             cout_d, cout_q;
    logic             ovf_d,  ovf_q;

    assign carry[0] = cin;

    // One full adder per bit; carries ripple strictly LSB to MSB.
    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign stage_sum[i] = a[i] ^ b[i] ^ carry[i];
        assign carry[i+1]   = (a[i] & b[i]) | (a[i] & carry[i]) | (b[i] & carry[i]);
    end

    always_comb begin
        sum_d  = stage_sum;
        cout_d = carry[WIDTH];
        ovf_d  = carry[WIDTH-1] ^ carry[WIDTH];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_ripple_circuit_adder.sv
// Self-checking bench for ripple_circuit_adder: WIDTH=4 and WIDTH=8 instances checked
// every cycle against an arithmetic reference, plus literal directed vectors.
module tb_ripple_circuit_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] a4 = '0, b4 = '0;
    logic       cin4 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       cin8 = 1'b0;
    logic [3:0] sum4;
    logic       cout4, ovf4;
    logic [7:0] sum8;
    logic       cout8, ovf8;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    logic [9:0] m4, m8;  // model results {ovf, cout, sum[7:0]}

    always #5 clk = ~clk;

    ripple_circuit_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4), .cin(cin4),
        .sum(sum4), .cout(cout4), .overflow(ovf4)
    );

    ripple_circuit_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .a(a8), .b(b8), .cin(cin8),
        .sum(sum8), .cout(cout8), .overflow(ovf8)
    );

    // Reference: unsigned sum/carry by integer addition, overflow by signed range check.
    function automatic logic [9:0] ref_add(int w, int ua, int ub, int c);
        int u, sa, sb, r, s, co;
        logic ov;
        logic [7:0] s8;
        u  = ua + ub + c;
        s  = u % (1 << w);
        co = u >> w;
        sa = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        sb = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        r  = sa + sb + c;
        ov = (r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1)));
        s8 = 8'(s);
        return {ov, co[0], s8};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m4 <= '0;
            m8 <= '0;
        end else begin
            m4 <= ref_add(4, int'(a4), int'(b4), int'(cin4));
            m8 <= ref_add(8, int'(a8), int'(b8), int'(cin8));
        end
    end

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            total++;
            if ({ovf4, cout4, sum4} !== {m4[9], m4[8], m4[3:0]}) begin
                bad++;
                $display("FAIL model4: got ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h",
                         ovf4, cout4, sum4, m4[9], m4[8], m4[3:0]);
            end
            total++;
            if ({ovf8, cout8, sum8} !== m8) begin
                bad++;
                $display("FAIL model8: got ovf=%b cout=%b sum=%h, want ovf=%b cout=%b sum=%h",
                         ovf8, cout8, sum8, m8[9], m8[8], m8[7:0]);
            end
        end
    end

    task automatic expect4(string name, logic [3:0] es, logic ec, logic eo, bit chk_ov);
        total++;
        if (sum4 !== es || cout4 !== ec || (chk_ov && ovf4 !== eo)) begin
            bad++;
            $display("FAIL %s: got sum=%b cout=%b ovf=%b, want sum=%b cout=%b ovf=%b",
                     name, sum4, cout4, ovf4, es, ec, eo);
        end
    endtask

    task automatic vec4(string name, logic [3:0] va, logic [3:0] vb, logic vc,
                        logic [3:0] es, logic ec, logic eo, bit chk_ov);
        @(negedge clk);
        #1;
        a4 = va; b4 = vb; cin4 = vc;
        @(posedge clk);
        #1;
        expect4(name, es, ec, eo, chk_ov);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;

        // Directed literal vectors on the 4-bit instance
        vec4("zero",      4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1);
        vec4("one_two",   4'b0001, 4'b0010, 1'b0, 4'b0011, 1'b0, 1'b0, 1'b1);
        vec4("carry_in",  4'b0101, 4'b0011, 1'b1, 4'b1001, 1'b0, 1'b1, 1'b1);
        vec4("wrap_1",    4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1);
        vec4("wrap_ff",   4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b1);
        vec4("wrap_ff_c", 4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
        vec4("ones_cin",  4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1);
        vec4("neg_ovf",   4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1);

        // 8-bit instance boundary
        @(negedge clk);
        #1;
        a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (sum8 !== 8'h00 || cout8 !== 1'b1) begin
            bad++;
            $display("FAIL w8_wrap: got sum=%h cout=%b, want sum=00 cout=1", sum8, cout8);
        end

        // Asynchronous reset mid-cycle with all-ones operands
        vec4("pre_reset", 4'b1111, 4'b1111, 1'b0, 4'b1110, 1'b1, 1'b0, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        expect4("reset_async", 4'b0000, 1'b0, 1'b0, 1'b1);
        repeat (2) begin
            @(posedge clk);
            #1;
            expect4("reset_hold", 4'b0000, 1'b0, 1'b0, 1'b1);
        end
        @(negedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        expect4("reset_release", 4'b1110, 1'b1, 1'b0, 1'b1);

        // Exhaustive back-to-back on the 4-bit instance, random on the 8-bit one
        for (int k = 0; k < 512; k++) begin
            @(negedge clk);
            #1;
            {cin4, a4, b4} = 9'(k);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        end

        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            #1;
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
        end

        @(negedge clk);
        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
